// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing the system Bridge between the CPU memory stage (0) and the debug/DMA port (1).
// Optional BRG_ARB_ADDR_CHECK_EN rejects out-of-window or misaligned addresses with a one-cycle error Ack.
`timescale 1ns/1ps

module bridge_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ARB_i_clk,
  input  logic              ARB_i_reset,
  input  logic              ARB_i_Req0,
  input  logic              ARB_i_Req1,
  input  logic [ADDR_W-1:0] ARB_i_Addr0,
  input  logic [ADDR_W-1:0] ARB_i_Addr1,
  input  logic              ARB_i_WEn0,
  input  logic              ARB_i_WEn1,
  input  logic [3:0]        ARB_i_ByteEn0,
  input  logic [3:0]        ARB_i_ByteEn1,
  input  logic [DATA_W-1:0] ARB_i_WData0,
  input  logic [DATA_W-1:0] ARB_i_WData1,
  output logic              ARB_o_Ack0,
  output logic              ARB_o_Ack1,
  output logic [DATA_W-1:0] ARB_o_RData,
  output logic              ARB_o_Err,
  output logic [ADDR_W-1:0] ARB_o_Addr,
  output logic [3:0]        ARB_o_ByteEnable,
  output logic [DATA_W-1:0] ARB_o_WData,
  output logic              ARB_o_WEnable,
  input  logic [DATA_W-1:0] ARB_i_RData
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2} state_t;

  state_t state, next_state;

  logic              last_grant;
  logic              grant;
  logic              winner;
  logic              start;
  logic              reject;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wen;
  logic [3:0]        sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    winner = ARB_i_Req1;
    if (ARB_i_Req0 && ARB_i_Req1) begin
      winner = ~last_grant;
    end
    sel_addr  = winner ? ARB_i_Addr1   : ARB_i_Addr0;
    sel_wen   = winner ? ARB_i_WEn1    : ARB_i_WEn0;
    sel_be    = winner ? ARB_i_ByteEn1 : ARB_i_ByteEn0;
    sel_wdata = winner ? ARB_i_WData1  : ARB_i_WData0;
  end

`ifdef BRG_ARB_ADDR_CHECK_EN
  logic addr_ok;
  logic err_q;

  assign addr_ok = (sel_addr[1:0] == 2'b00) &&
                   (((sel_addr >= ADDR_W'(32'h7F00)) && (sel_addr <= ADDR_W'(32'h7F0B))) ||
                    ((sel_addr >= ADDR_W'(32'h7F10)) && (sel_addr <= ADDR_W'(32'h7F1B))));
  assign ARB_o_Err = err_q;
`else
  assign ARB_o_Err = 1'b0;
`endif

  always_ff @(posedge ARB_i_clk) begin
    if (ARB_i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (ARB_i_Req0 || ARB_i_Req1) begin
          start      = 1'b1;
          next_state = ISSUE;
`ifdef BRG_ARB_ADDR_CHECK_EN
          if (!addr_ok) begin
            reject     = 1'b1;
            next_state = ACK;
          end
`endif
        end
      end
      ISSUE:   next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bridge outputs hold the latched request only during ISSUE; a rejected request never touches them.
  always_ff @(posedge ARB_i_clk) begin
    if (ARB_i_reset) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef BRG_ARB_ADDR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (start) begin
        grant <= winner;
`ifdef BRG_ARB_ADDR_CHECK_EN
        err_q <= reject;
`endif
        if (reject) begin
          last_grant <= winner;
          rdata_q    <= '0;
        end else begin
          addr_q  <= sel_addr;
          wen_q   <= sel_wen;
          be_q    <= sel_be;
          wdata_q <= sel_wdata;
        end
      end
      if (state == ISSUE) begin
        rdata_q    <= ARB_i_RData;
        last_grant <= grant;
        addr_q     <= '0;
        be_q       <= '0;
        wdata_q    <= '0;
      end
    end
  end

  assign ARB_o_Ack0       = (state == ACK) && !grant;
  assign ARB_o_Ack1       = (state == ACK) && grant;
  assign ARB_o_WEnable    = (state == ISSUE) && wen_q;
  assign ARB_o_RData      = rdata_q;
  assign ARB_o_Addr       = addr_q;
  assign ARB_o_ByteEnable = be_q;
  assign ARB_o_WData      = wdata_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter: directed requests push expected Bridge cycles and Acks,
// negedge monitors pop and compare whenever the DUT drives the Bridge or pulses an Ack.
`timescale 1ns/1ps

module tb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        wen0, wen1;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata_out;
  logic        err;
  logic [31:0] brg_addr;
  logic [3:0]  brg_be;
  logic [31:0] brg_wdata;
  logic        brg_wen;
  logic [31:0] brg_rdata;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } ack_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          wen;
    int          cyc;
  } brg_exp_t;

  ack_exp_t ack_q[$];
  brg_exp_t brg_q[$];
  ack_exp_t ae;
  brg_exp_t bre;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bridge_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ARB_i_clk(clk),
    .ARB_i_reset(reset),
    .ARB_i_Req0(req0),
    .ARB_i_Req1(req1),
    .ARB_i_Addr0(addr0),
    .ARB_i_Addr1(addr1),
    .ARB_i_WEn0(wen0),
    .ARB_i_WEn1(wen1),
    .ARB_i_ByteEn0(be0),
    .ARB_i_ByteEn1(be1),
    .ARB_i_WData0(wdata0),
    .ARB_i_WData1(wdata1),
    .ARB_o_Ack0(ack0),
    .ARB_o_Ack1(ack1),
    .ARB_o_RData(rdata_out),
    .ARB_o_Err(err),
    .ARB_o_Addr(brg_addr),
    .ARB_o_ByteEnable(brg_be),
    .ARB_o_WData(brg_wdata),
    .ARB_o_WEnable(brg_wen),
    .ARB_i_RData(brg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bridge read model: one fixed register, everything else echoes its address.
  function automatic logic [31:0] bridge_model(input logic [31:0] a);
    if (a == 32'h0000_7F04) return 32'h1234_5670;
    return {16'hBEEF, a[15:0]};
  endfunction

  assign brg_rdata = bridge_model(brg_addr);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)", ack0, ack1, cyc);
      end else begin
        ae = ack_q.pop_front();
        checkOutput("ack_id", {62'd0, ack1, ack0}, (ae.id == 1) ? 64'd2 : 64'd1);
        checkOutput("ack_cycle", 64'(cyc), 64'(ae.cyc));
        if (ae.chk_rd) checkOutput("ack_rdata", 64'(rdata_out), 64'(ae.rdata));
        checkOutput("ack_err", 64'(err), 64'(ae.err));
      end
    end
    if (brg_wen || (brg_addr != 32'd0)) begin
      if (brg_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_bridge: got addr=0x%0h wen=%0b expected idle (cycle %0d)", brg_addr, brg_wen, cyc);
      end else begin
        bre = brg_q.pop_front();
        checkOutput("brg_addr", 64'(brg_addr), 64'(bre.addr));
        checkOutput("brg_be", 64'(brg_be), 64'(bre.be));
        checkOutput("brg_wdata", 64'(brg_wdata), 64'(bre.wdata));
        checkOutput("brg_wen", 64'(brg_wen), 64'(bre.wen));
        checkOutput("brg_cycle", 64'(cyc), 64'(bre.cyc));
      end
    end
  end

  task automatic drive(input int id, input bit req, input logic [31:0] a, input bit w,
                       input logic [3:0] b, input logic [31:0] d);
    if (id == 0) begin
      req0 = req; addr0 = a; wen0 = w; be0 = b; wdata0 = d;
    end else begin
      req1 = req; addr1 = a; wen1 = w; be1 = b; wdata1 = d;
    end
  endtask

  task automatic pushBridge(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                            input bit w, input int at);
    brg_exp_t x;
    x.addr = a; x.be = b; x.wdata = d; x.wen = w; x.cyc = at;
    brg_q.push_back(x);
  endtask

  task automatic pushAck(input int id, input logic [31:0] rd, input bit chk, input bit e, input int at);
    ack_exp_t x;
    x.id = id; x.rdata = rd; x.chk_rd = chk; x.err = e; x.cyc = at;
    ack_q.push_back(x);
  endtask

  // Called just after a rising edge; holds Req until the Ack, then drops it on the edge ending the Ack.
  task automatic applyStimulus(input int id, input logic [31:0] a, input bit w, input logic [3:0] b,
                               input logic [31:0] d, input bit issues, input logic [31:0] exp_rd,
                               input bit chk_rd, input bit exp_err);
    bit got;
    if (issues) begin
      pushBridge(a, b, d, w, cyc + 1);
      pushAck(id, exp_rd, chk_rd, exp_err, cyc + 2);
    end else begin
      pushAck(id, exp_rd, chk_rd, exp_err, cyc + 1);
    end
    drive(id, 1'b1, a, w, b, d);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? ack0 : ack1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ack from requester %0d expected one within 8 cycles", id);
    end
    @(posedge clk);
    #1;
    drive(id, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    int n;
    drive(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    drive(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_ack0", 64'(ack0), 64'd0);
    checkOutput("rst_ack1", 64'(ack1), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_wen", 64'(brg_wen), 64'd0);
    checkOutput("rst_addr", 64'(brg_addr), 64'd0);
    checkOutput("rst_be", 64'(brg_be), 64'd0);
    checkOutput("rst_wdata", 64'(brg_wdata), 64'd0);
    checkOutput("rst_rdata", 64'(rdata_out), 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(0, 32'h7F04, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1234_5670, 1'b1, 1'b0);
    applyStimulus(1, 32'h7F10, 1'b1, 4'hF, 32'hDD11_AA88, 1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 32'h7F18, 1'b0, 4'b0011, 32'h0, 1'b1, 32'hBEEF_7F18, 1'b1, 1'b0);

    // Reset lands on the edge that ends ISSUE of a write: no Ack may follow.
    pushBridge(32'h7F08, 4'b1100, 32'hCAFE_0000, 1'b1, cyc + 1);
    drive(0, 1'b1, 32'h7F08, 1'b1, 4'b1100, 32'hCAFE_0000);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("post_rst_wen", 64'(brg_wen), 64'd0);
    checkOutput("post_rst_addr", 64'(brg_addr), 64'd0);
    checkOutput("post_rst_ack0", 64'(ack0), 64'd0);
    @(posedge clk);
    #1;

    // Both requesters held high: grants alternate 0,1,0,1 starting with 0.
    n = cyc;
    pushBridge(32'h7F00, 4'hF, 32'h0, 1'b0, n + 1);
    pushAck(0, 32'hBEEF_7F00, 1'b1, 1'b0, n + 2);
    pushBridge(32'h7F14, 4'hF, 32'h0, 1'b0, n + 4);
    pushAck(1, 32'hBEEF_7F14, 1'b1, 1'b0, n + 5);
    pushBridge(32'h7F00, 4'hF, 32'h0, 1'b0, n + 7);
    pushAck(0, 32'hBEEF_7F00, 1'b1, 1'b0, n + 8);
    pushBridge(32'h7F14, 4'hF, 32'h0, 1'b0, n + 10);
    pushAck(1, 32'hBEEF_7F14, 1'b1, 1'b0, n + 11);
    drive(0, 1'b1, 32'h7F00, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h7F14, 1'b0, 4'hF, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    drive(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(posedge clk);
    #1;

`ifdef BRG_ARB_ADDR_CHECK_EN
    applyStimulus(0, 32'h7F20, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
`else
    applyStimulus(0, 32'h7F20, 1'b0, 4'hF, 32'h0, 1'b1, 32'hBEEF_7F20, 1'b1, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("ack_q_drained", 64'(ack_q.size()), 64'd0);
    checkOutput("brg_q_drained", 64'(brg_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion expected finish before 100000ns");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
